// File: rtl/dff_four_bits_pkg.sv
// Shared widths and controller state encodings for the signed-digit multiplier
// delay registers.
package dff_four_bits_pkg;

    localparam int DIGIT_W_DEF = 4;
    localparam int STATE_W_DEF = 2;

    // Controller states; the downstream delay logic compares prev_state against these.
    typedef enum logic [STATE_W_DEF-1:0] {
        STATE_IDLE  = 2'b00,
        STATE_RUN   = 2'b01,
        STATE_SHIFT = 2'b10
    } ctrl_state_e;

    // Both digit vectors set in the same position: stored as given, flagged only for observers.
    function automatic logic digit_pair_illegal(input logic [DIGIT_W_DEF-1:0] plus,
                                                input logic [DIGIT_W_DEF-1:0] minus);
        return |(plus & minus);
    endfunction

endpackage

// File: rtl/dff_two_bits.sv
// Enable-gated state register with synchronous clear; holds the controller
// state for one cycle.
module dff_two_bits
    import dff_four_bits_pkg::*;
#(
    parameter int WIDTH = STATE_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Defined before the first reset.
    logic [WIDTH-1:0] state_q = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
        end else if (write_enable) begin
            state_q <= d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/dff_four_bits.sv
// Enable-gated delay register for the redundant digit pair plus the controller
// state; all fields load together so they never differ in age.
module dff_four_bits
    import dff_four_bits_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_enable,
    input  logic [DIGIT_W-1:0] x_plus,
    input  logic [DIGIT_W-1:0] x_minus,
    input  logic [STATE_W-1:0] states,
    output logic [DIGIT_W-1:0] x_plus_delayed,
    output logic [DIGIT_W-1:0] x_minus_delayed,
    output logic [STATE_W-1:0] prev_state
);

    logic [DIGIT_W-1:0] x_plus_q  = '0;
    logic [DIGIT_W-1:0] x_minus_q = '0;

    // No encoding check: an illegal digit pair is stored exactly as presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_plus_q  <= '0;
            x_minus_q <= '0;
        end else if (write_enable) begin
            x_plus_q  <= x_plus;
            x_minus_q <= x_minus;
        end
    end

    dff_two_bits #(
        .WIDTH(STATE_W)
    ) u_state_reg (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .d            (states),
        .q            (prev_state)
    );

    assign x_plus_delayed  = x_plus_q;
    assign x_minus_delayed = x_minus_q;

endmodule

// File: tb/tb_dff_four_bits.sv
// Directed bench for dff_four_bits: expected outputs are queued as each edge is
// driven and compared one edge later.
module tb_dff_four_bits;

    typedef struct packed {
        logic [3:0] xp;
        logic [3:0] xm;
        logic [1:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write_enable = 1'b0;
    logic [3:0] x_plus = '0;
    logic [3:0] x_minus = '0;
    logic [1:0] states = '0;
    logic [3:0] x_plus_delayed;
    logic [3:0] x_minus_delayed;
    logic [1:0] prev_state;

    int   errors = 0;
    int   checks = 0;
    exp_t model = '0;
    exp_t sb[$];

    dff_four_bits dut (
        .clk             (clk),
        .rst             (rst),
        .write_enable    (write_enable),
        .x_plus          (x_plus),
        .x_minus         (x_minus),
        .states          (states),
        .x_plus_delayed  (x_plus_delayed),
        .x_minus_delayed (x_minus_delayed),
        .prev_state      (prev_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".x_plus_delayed"},  32'(x_plus_delayed),  32'(e.xp));
        check({tag, ".x_minus_delayed"}, 32'(x_minus_delayed), 32'(e.xm));
        check({tag, ".prev_state"},      32'(prev_state),      32'(e.st));
    endtask

    task automatic drive(input logic r, input logic we, input logic [3:0] xp,
                         input logic [3:0] xm, input logic [1:0] st);
        rst = r;
        write_enable = we;
        x_plus = xp;
        x_minus = xm;
        states = st;
    endtask

    // Predict the value captured at the coming edge, then compare after it.
    task automatic tick(input string tag);
        exp_t e;
        if (rst)               e = '0;
        else if (write_enable) e = '{xp: x_plus, xm: x_minus, st: states};
        else                   e = model;
        sb.push_back(e);
        check_all({tag, ".pre"}, model);
        @(posedge clk);
        #1;
        model = e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            check_all(tag, sb.pop_front());
        end
    endtask

    initial begin
        #1;
        check_all("powerup", '0);

        drive(1'b1, 1'b1, 4'b0110, 4'b1011, 2'b11);
        tick("reset");

        drive(1'b0, 1'b1, 4'b1010, 4'b0101, 2'b10);
        tick("capture");

        drive(1'b0, 1'b1, 4'b0011, 4'b1100, 2'b01);
        tick("hold_load");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'b1111, 4'b0000, 2'b11);
            tick("hold");
        end

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), ~4'(i), 2'(i % 3));
            tick("delay_line");
        end

        // Illegal digit pair is stored unchanged.
        drive(1'b0, 1'b1, 4'b1101, 4'b0111, 2'b00);
        tick("illegal_pair");

        drive(1'b0, 1'b1, 4'b1001, 4'b0110, 2'b10);
        tick("mid_load");
        drive(1'b1, 1'b1, 4'b1111, 4'b1111, 2'b11);
        tick("mid_reset");
        drive(1'b0, 1'b1, 4'b0001, 4'b0010, 2'b01);
        tick("post_reset");

        // Enable pulse strictly between edges must not load.
        drive(1'b0, 1'b0, 4'b1110, 4'b1000, 2'b10);
        #2 write_enable = 1'b1;
        #2 write_enable = 1'b0;
        check_all("pulse_mid", model);
        tick("pulse_edge");

        drive(1'b0, 1'b0, 4'b0101, 4'b0101, 2'b01);
        tick("idle_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks);
        $fatal(1, "timeout");
    end

endmodule
